// File: rtl/hnoc_pkg.sv
// Shared constants and helpers for the hnoc switch: destination-field extraction,
// FIFO pointer width and statistics counter width.
package hnoc_pkg;

  localparam int StatsW   = 16;
  localparam int MaxDataW = 256;
  localparam int MaxAddrW = 16;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Destination occupies the top addr_w bits of a data_w-bit flit.
  function automatic logic [MaxAddrW-1:0] dest_of(input logic [MaxDataW-1:0] flit,
                                                  input int data_w, input int addr_w);
    logic [MaxAddrW-1:0] d;
    d = '0;
    for (int i = 0; i < MaxAddrW; i++) begin
      if (i < addr_w) d[i] = flit[data_w - addr_w + i];
    end
    return d;
  endfunction

endpackage

// File: rtl/hnoc_fifo.sv
// Single-clock input FIFO with a registered read port; a freshly written entry
// becomes visible at the head one cycle after it was written.
module hnoc_fifo
  import hnoc_pkg::*;
#(
  parameter int Width = 36,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = ptr_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d, remain;
  logic [Width-1:0] rd_data_q;
  logic             head_vld_q;
  logic             wr_ok, rd_ok;

  assign full_o   = (count_q == (PtrW+1)'(Depth));
  assign empty_o  = ~head_vld_q;
  assign wr_ok    = wr_en_i & ~full_o;
  assign rd_ok    = rd_en_i & head_vld_q;
  assign rd_ptr_d = rd_ptr_q + PtrW'(rd_ok);
  assign remain   = count_q - (PtrW+1)'(rd_ok);
  assign count_d  = remain + (PtrW+1)'(wr_ok);
  assign rd_data_o = rd_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + PtrW'(wr_ok);
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      // Only entries written before this edge are readable from memory now.
      head_vld_q <= (remain != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    rd_data_q <= mem_q[rd_ptr_d];
  end

endmodule

// File: rtl/hnoc_nport_switch.sv
// N-port flit switch: per-input FIFOs, address-range routing, round-robin egress
// arbitration into one-entry output registers. HNOC_STATS_EN adds per-egress flit counters.
module hnoc_nport_switch
  import hnoc_pkg::*;
#(
  parameter int DataWidth = 36,
  parameter int AddrWidth = 4,
  parameter int NumPorts  = 4,
  parameter int FifoDepth = 4,
  parameter logic [NumPorts*AddrWidth-1:0] PortMin = '0,
  parameter logic [NumPorts*AddrWidth-1:0] PortMax = '0,
  parameter int UpPort    = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NumPorts*DataWidth-1:0] i_data,
  input  logic [NumPorts-1:0]           i_data_valid,
  output logic [NumPorts-1:0]           o_data_ready,
  output logic [NumPorts*DataWidth-1:0] o_data,
  output logic [NumPorts-1:0]           o_data_valid,
  input  logic [NumPorts-1:0]           i_data_ready
`ifdef HNOC_STATS_EN
  ,
  output logic [NumPorts*StatsW-1:0]    o_flit_count
`endif
);

  localparam int IdxW = $clog2(NumPorts);

  logic                 rdy_en_q;
  logic [NumPorts-1:0]  full, empty, push, pop, load_en, gnt_vld, out_vld_q;
  logic [DataWidth-1:0] head [NumPorts];
  logic [DataWidth-1:0] out_q [NumPorts];
  logic [MaxAddrW-1:0]  dest [NumPorts];
  logic [IdxW-1:0]      route [NumPorts];
  logic [IdxW-1:0]      gnt_idx [NumPorts];
  logic [IdxW-1:0]      rr_ptr_q [NumPorts];

  assign o_data_ready = {NumPorts{rdy_en_q}} & ~full;
  assign push         = i_data_valid & o_data_ready;
  assign load_en      = ~out_vld_q | i_data_ready;
  assign o_data_valid = out_vld_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    hnoc_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_fifo (
      .clk_i    (i_clk),
      .rst_i    (i_reset),
      .wr_en_i  (push[p]),
      .wr_data_i(i_data[p*DataWidth +: DataWidth]),
      .rd_en_i  (pop[p]),
      .rd_data_o(head[p]),
      .full_o   (full[p]),
      .empty_o  (empty[p])
    );
    assign o_data[p*DataWidth +: DataWidth] = out_q[p];
  end

  // Lowest-index matching range wins; unmatched addresses go upstream.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      dest[p]  = dest_of(MaxDataW'(head[p]), DataWidth, AddrWidth);
      route[p] = IdxW'(UpPort);
      for (int q = NumPorts - 1; q >= 0; q--) begin
        if (dest[p] >= MaxAddrW'(PortMin[q*AddrWidth +: AddrWidth]) &&
            dest[p] <= MaxAddrW'(PortMax[q*AddrWidth +: AddrWidth]))
          route[p] = IdxW'(q);
      end
    end
  end

  always_comb begin
    int cand;
    cand = 0;
    for (int q = 0; q < NumPorts; q++) begin
      gnt_vld[q] = 1'b0;
      gnt_idx[q] = '0;
      for (int i = 0; i < NumPorts; i++) begin
        cand = int'(rr_ptr_q[q]) + i;
        if (cand >= NumPorts) cand = cand - NumPorts;
        if (load_en[q] && !gnt_vld[q] && !empty[cand] && route[cand] == IdxW'(q)) begin
          gnt_vld[q] = 1'b1;
          gnt_idx[q] = IdxW'(cand);
        end
      end
    end
  end

  // Each head routes to exactly one egress, so an input is granted at most once.
  always_comb begin
    pop = '0;
    for (int p = 0; p < NumPorts; p++) begin
      for (int q = 0; q < NumPorts; q++) begin
        if (gnt_vld[q] && gnt_idx[q] == IdxW'(p)) pop[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdy_en_q <= 1'b0;
      for (int q = 0; q < NumPorts; q++) begin
        out_q[q]     <= '0;
        out_vld_q[q] <= 1'b0;
        rr_ptr_q[q]  <= '0;
      end
    end else begin
      rdy_en_q <= 1'b1;
      for (int q = 0; q < NumPorts; q++) begin
        if (load_en[q]) begin
          out_vld_q[q] <= gnt_vld[q];
          if (gnt_vld[q]) begin
            out_q[q]    <= head[gnt_idx[q]];
            rr_ptr_q[q] <= (gnt_idx[q] == IdxW'(NumPorts - 1)) ? '0 : gnt_idx[q] + IdxW'(1);
          end
        end
      end
    end
  end

`ifdef HNOC_STATS_EN
  logic [StatsW-1:0] cnt_q [NumPorts];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int q = 0; q < NumPorts; q++) cnt_q[q] <= '0;
    end else begin
      for (int q = 0; q < NumPorts; q++) begin
        if (out_vld_q[q] && i_data_ready[q]) cnt_q[q] <= cnt_q[q] + StatsW'(1);
      end
    end
  end

  for (genvar q = 0; q < NumPorts; q++) begin : g_cnt
    assign o_flit_count[q*StatsW +: StatsW] = cnt_q[q];
  end
`endif

endmodule
